// File: rtl/rr_grant_ctrl_pkg.sv
// Shared arbiter types, limits and the rotate helper used for pointer-masked
// priority search. Imported by the rr_grant_ctrl block and its encoder.
package util_pkg;

  localparam int ARB_MAX_REQ = 16;
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  // Rotates the low 'width' bits of vec left by amt (amt < width); upper bits stay 0.
  function automatic logic [ARB_MAX_REQ-1:0] rotate_left(
    input logic [ARB_MAX_REQ-1:0] vec,
    input int unsigned            amt,
    input int unsigned            width = ARB_MAX_REQ
  );
    logic [ARB_MAX_REQ-1:0] res;
    int unsigned            j;
    res = '0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      if (i < width) begin
        j = i + amt;
        if (j >= width) j = j - width;
        res[j[ARB_IDX_W-1:0]] = vec[i[ARB_IDX_W-1:0]];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Requester-side bundle of the round-robin arbiter: request vector in,
// registered grant, owner index, valid and preemption pulse out.
interface rr_grant_ctrl_if #(
  parameter int N_REQ = 4
) ();

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] grant_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             grant_valid_o;
  logic             preempt_o;

  modport master (
    output req_i,
    input  grant_o, grant_idx_o, grant_valid_o, preempt_o
  );

  modport slave (
    input  req_i,
    output grant_o, grant_idx_o, grant_valid_o, preempt_o
  );

endinterface

// File: rtl/rr_grant_ctrl_prio_enc.sv
// Combinational rotating priority encoder: first set bit of req_i at or after
// start_i, wrapping around; returns one-hot winner, its index and found.
module rr_prio_enc
  import util_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [ARB_MAX_REQ-1:0] rot;
  logic [ARB_MAX_REQ-1:0] first;
  logic [ARB_IDX_W-1:0]   pos;
  logic                   hit;
  int                     back;
  int                     sum;

  always_comb begin
    // Rotate right by start_i so the start position lands on bit 0.
    back = (start_i == '0) ? 0 : N_REQ - int'(start_i);
    rot  = rotate_left(ARB_MAX_REQ'(req_i), back, N_REQ);
    hit  = 1'b0;
    pos  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[ARB_IDX_W'(i)] && !hit) begin
        hit = 1'b1;
        pos = ARB_IDX_W'(i);
      end
    end
    first      = '0;
    first[pos] = hit;
    grant_oh_o = N_REQ'(rotate_left(first, int'(start_i), N_REQ));
    sum        = int'(start_i) + int'(pos);
    if (sum >= N_REQ) sum = sum - N_REQ;
    idx_o   = IDX_W'(sum);
    found_o = hit;
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller with registered one-hot grants held while the
// owner requests. Optional forced rotation: define RR_GRANT_CTRL_HOLD_LIMIT_EN.
module rr_grant_ctrl
  import util_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input logic             clk,
  input logic             rst_n,
  rr_grant_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] start;
  logic [N_REQ-1:0] req_arb;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  logic             owner_req;
  logic             other_req;
  logic             force_rot;
  logic             limit_hit;

  assign start     = (last_q == LAST_RST) ? '0 : last_q + 1'b1;
  assign owner_req = |(bus.req_i & grant_q);
  assign other_req = |(bus.req_i & ~grant_q);
  assign force_rot = (state_q == ARB_OWNED) && owner_req && other_req && limit_hit;
  assign req_arb   = force_rot ? (bus.req_i & ~grant_q) : bus.req_i;

  rr_prio_enc #(.N_REQ(N_REQ)) u_prio_enc (
    .req_i      (req_arb),
    .start_i    (start),
    .grant_oh_o (win_oh),
    .idx_o      (win_idx),
    .found_o    (found)
  );

`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;
  // Saturating at the limit lets a late competitor trigger rotation at once.
  assign limit_hit = (cnt_q >= CNT_LIM);
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_OWNED;
          grant_d = win_oh;
          idx_d   = win_idx;
          last_d  = win_idx;
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
          cnt_d = '0;
`endif
        end
      end
      ARB_OWNED: begin
        if (owner_req && !force_rot) begin
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
          cnt_d = limit_hit ? cnt_q : cnt_q + 1'b1;
`endif
        end else if (found) begin
          grant_d = win_oh;
          idx_d   = win_idx;
          last_d  = win_idx;
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
          cnt_d     = '0;
          preempt_d = force_rot;
`endif
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
          cnt_d = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus.preempt_o = preempt_q;
`else
  assign bus.preempt_o = 1'b0;
`endif

  assign bus.grant_o       = grant_q;
  assign bus.grant_idx_o   = idx_q;
  assign bus.grant_valid_o = (state_q == ARB_OWNED);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_param_range: assert property (@(posedge clk)
    (N_REQ >= 2) && (N_REQ <= ARB_MAX_REQ) && (MAX_HOLD >= 2) && (MAX_HOLD <= 256));

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed scenarios plus randomized
// requests against a behavioural round-robin model.
module tb_rr_grant_ctrl;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl_if #(.N_REQ(N)) rr_if ();

  rr_grant_ctrl #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rr_if)
  );

  // Reference model: owner (-1 = none), priority pointer, cycles held so far.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_held  = 0;
  int m_idx   = 0;
  bit m_pre   = 1'b0;

  function automatic int search(input logic [N-1:0] r, input int from_last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from_last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic rn);
    int w;
    bit keep, forced;
    logic [N-1:0] rr;
    if (!rn) begin
      m_owner = -1; m_last = N - 1; m_held = 0; m_pre = 1'b0; m_idx = 0;
    end else begin
      m_pre = 1'b0;
      if (m_owner < 0) begin
        w = search(r, m_last);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_held = 1; m_idx = w;
        end
      end else begin
        keep   = r[m_owner];
        rr     = r;
        rr[m_owner] = 1'b0;
        forced = HOLD_EN && keep && (m_held >= MH) && (rr != '0);
        if (keep && !forced) begin
          m_held++;
        end else begin
          w = search(rr, m_last);
          if (w >= 0) begin
            m_owner = w; m_last = w; m_held = 1; m_idx = w; m_pre = forced;
          end else begin
            m_owner = -1;
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic rn);
    rr_if.req_i = r;
    rst_n = rn;
    @(posedge clk);
    model_update(r, rn);
    #1;
  endtask

  task automatic test_reset();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    n_tests++;
    if (rr_if.grant_o !== 4'b0000 || rr_if.grant_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grant: got grant=%b valid=%b expected 0000/0", rr_if.grant_o, rr_if.grant_valid_o);
    end
    n_tests++;
    if (rr_if.grant_idx_o !== 2'd0 || rr_if.preempt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idx: got idx=%0d preempt=%b expected 0/0", rr_if.grant_idx_o, rr_if.preempt_o);
    end
    step(4'b1111, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0001 || rr_if.grant_idx_o !== 2'd0 || rr_if.grant_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got grant=%b idx=%0d expected 0001/0", rr_if.grant_o, rr_if.grant_idx_o);
    end
    $display("[TB] test_reset done: grant=%b", rr_if.grant_o);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    for (int o = 0; o < 5; o++) begin
      exp_g = 4'b0001 << (o % N);
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (rr_if.grant_o !== exp_g || rr_if.grant_valid_o !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_owner%0d_cyc%0d: got grant=%b valid=%b expected %b/1", o, c, rr_if.grant_o, rr_if.grant_valid_o, exp_g);
        end
        if (c < 2) step(4'b1111, 1'b1);
      end
      step(4'b1111 & ~exp_g, 1'b1);
      $display("[TB] round_robin handoff from owner %0d -> grant=%b", o % N, rr_if.grant_o);
    end
  endtask

  task automatic test_wrap_skip();
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_setup: got grant=%b expected 0100", rr_if.grant_o);
    end
    step(4'b0011, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0001 || rr_if.grant_idx_o !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_skip: got grant=%b idx=%0d expected 0001/0", rr_if.grant_o, rr_if.grant_idx_o);
    end
    $display("[TB] test_wrap_skip: grant=%b", rr_if.grant_o);
  endtask

  task automatic test_idle_return();
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0000 || rr_if.grant_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_return: got grant=%b valid=%b expected 0000/0", rr_if.grant_o, rr_if.grant_valid_o);
    end
    step(4'b0000, 1'b1);
    step(4'b1010, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b1000 || rr_if.grant_idx_o !== 2'd3) begin
      n_fail++;
      $display("FAIL idle_regrant: got grant=%b idx=%0d expected 1000/3", rr_if.grant_o, rr_if.grant_idx_o);
    end
    $display("[TB] test_idle_return: grant=%b", rr_if.grant_o);
  endtask

  task automatic test_hold_limit();
    step(4'b0000, 1'b0);
    step(4'b0101, 1'b1);
`ifdef RR_GRANT_CTRL_HOLD_LIMIT_EN
    for (int c = 0; c < MH; c++) begin
      n_tests++;
      if (rr_if.grant_o !== 4'b0001 || rr_if.preempt_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cyc%0d: got grant=%b preempt=%b expected 0001/0", c, rr_if.grant_o, rr_if.preempt_o);
      end
      step(4'b0101, 1'b1);
    end
    n_tests++;
    if (rr_if.grant_o !== 4'b0100 || rr_if.preempt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_preempt: got grant=%b preempt=%b expected 0100/1", rr_if.grant_o, rr_if.preempt_o);
    end
    step(4'b0101, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0100 || rr_if.preempt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_pulse_end: got grant=%b preempt=%b expected 0100/0", rr_if.grant_o, rr_if.preempt_o);
    end
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b1);
    for (int c = 0; c < 3 * MH; c++) step(4'b0001, 1'b1);
`else
    for (int c = 0; c < 3 * MH; c++) step(4'b0101, 1'b1);
`endif
    n_tests++;
    if (rr_if.grant_o !== 4'b0001 || rr_if.preempt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_keep: got grant=%b preempt=%b expected 0001/0", rr_if.grant_o, rr_if.preempt_o);
    end
    $display("[TB] test_hold_limit: grant=%b preempt=%b", rr_if.grant_o, rr_if.preempt_o);
  endtask

  task automatic test_mid_reset();
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0101, 1'b1);
    step(4'b0101, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_owner: got grant=%b expected 0100", rr_if.grant_o);
    end
    step(4'b0101, 1'b0);
    n_tests++;
    if (rr_if.grant_o !== 4'b0000 || rr_if.grant_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got grant=%b valid=%b expected 0000/0", rr_if.grant_o, rr_if.grant_valid_o);
    end
    step(4'b0101, 1'b1);
    n_tests++;
    if (rr_if.grant_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_regrant: got grant=%b expected 0001", rr_if.grant_o);
    end
    $display("[TB] test_mid_reset: grant=%b", rr_if.grant_o);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         rn;
    int           fails_before;
    fails_before = n_fail;
    r = '0;
    step(r, 1'b0);
    for (int t = 0; t < 1500; t++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
      end
      rn = ($urandom_range(63, 0) != 0);
      step(r, rn);
      n_tests++;
      if (rr_if.grant_o !== m_grant() || rr_if.grant_valid_o !== (m_owner >= 0)) begin
        n_fail++;
        $display("FAIL rand_grant t=%0d req=%b: got grant=%b valid=%b expected %b/%b", t, r, rr_if.grant_o, rr_if.grant_valid_o, m_grant(), (m_owner >= 0));
      end
      n_tests++;
      if (rr_if.preempt_o !== m_pre) begin
        n_fail++;
        $display("FAIL rand_preempt t=%0d: got %b expected %b", t, rr_if.preempt_o, m_pre);
      end
      n_tests++;
      if (rr_if.grant_idx_o !== 2'(m_idx)) begin
        n_fail++;
        $display("FAIL rand_idx t=%0d: got %0d expected %0d", t, rr_if.grant_idx_o, m_idx);
      end
    end
    $display("[TB] test_random: 1500 cycles, %0d new failures", n_fail - fails_before);
  endtask

  initial begin
    rr_if.req_i = '0;
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_idle_return();
    test_hold_limit();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter that shares one downstream resource (bus port, shared memory bank or datapath unit) between `N_REQ` requesters. Grants are registered, one-hot and held for as long as the owner keeps its request asserted. An optional hold-limit forces rotation so that a single requester cannot starve the others. It sits between the requester-side logic and the shared resource's mux select.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 16: maximum consecutive granted cycles before a forced rotation. Used only with the configuration macro; legal range 2..256.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `req_i`  in  N_REQ: request vector; bit k is requester k.
- `grant_o`  out  N_REQ: one-hot or all-zero grant, registered; reset value 0.
- `grant_idx_o`  out  $clog2(N_REQ): index of the current owner, registered; reset value 0; valid only when `grant_valid_o`=1.
- `grant_valid_o`  out  1: equals |grant_o; registered; reset value 0.
- `preempt_o`  out  1: one-cycle pulse in the cycle after a forced rotation takes effect; reset value 0.

## Operation
- State machine uses `util_pkg::arb_state_e` with two states:
  - IDLE: no owner.
  - OWNED: `grant_o` has exactly one bit set.
- Priority pointer `last_q` holds the most recent owner. The reset value is N_REQ-1, so requester 0 has top priority after reset.
- Arbitration searches `req_i` starting at index (last_q+1) mod N_REQ and wraps around. The first asserted bit wins.
- IDLE:
  - If `req_i`≠0, go to OWNED with the winner, set `last_q` to the winner and clear the hold counter.
  - Otherwise stay in IDLE.
- OWNED, owner's request still high and no forced rotation: keep the grant. Other requests are ignored.
- OWNED, owner's request low:
  - Arbitrate in the same edge. The search excludes the old owner because its request is low.
  - If a winner exists, hand off to it directly, with no bubble cycle.
  - If no winner exists, go to IDLE. `last_q` is kept.
- Requests are level-sensitive. A requester that drops its request before it is granted is simply not granted; nothing is latched.
- Simultaneous release by the owner and a new request from the same requester: the request is treated as high, so the owner keeps the grant. Release requires `req_i[owner]`=0 for at least one sampled edge.
- If `rst_n`=0 in any cycle, including mid-grant: the next edge forces IDLE, clears `grant_o`, sets `last_q` to N_REQ-1 and clears the counter. `rst_n` overrides every other input.
- `grant_o` never has more than one bit set. This is checked by an assertion in the RTL.

## Timing
- Latency is 1 cycle: `req_i` sampled at edge t gives `grant_o` valid after edge t.
- The earliest a requester is granted after `req_i` rises is 1 cycle.
- Worst-case wait without forced rotation is unbounded, because an owner may hold forever.
- Worst-case wait with the macro defined is (N_REQ-1)·MAX_HOLD+1 cycles.
- Handoff: the owner drops `req_i` before edge t, and the new grant is visible after edge t. Ownership is contiguous.
- The hold counter is `$clog2(MAX_HOLD)+1` bits wide and increments once per OWNED cycle.

## Configuration
- Macro: `RR_GRANT_CTRL_HOLD_LIMIT_EN`.
- Defined:
  - In OWNED, when the counter reaches MAX_HOLD-1 and any other request bit is high, the next edge forces arbitration with the owner excluded.
  - `preempt_o` pulses for 1 cycle and the counter clears.
  - If no other request bit is high, the counter saturates and the owner keeps the grant.
- Not defined:
  - The counter is not instantiated and `MAX_HOLD` is unused.
  - `preempt_o` is tied to 0.
  - Grants are held until the owner releases.

## Structure
- Shared items in `util_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e`.
  - Function `rotate_left(vec, amt)`, used for pointer-masked search.
  - Constant `ARB_MAX_REQ = 16`.
- One sub-module, `rr_prio_enc`, with ports: in `N_REQ`-bit request, in start index, out one-hot winner, out index, out found. It is purely combinational. It rotates, finds the first set bit and rotates back.
- `rr_grant_ctrl` holds the FSM, `last_q`, the hold counter and the output registers.

## Test plan
- Reset: hold `rst_n`=0 with `req_i`=4'b1111, then release → `grant_o`=4'b0001 one cycle after the first edge with `rst_n`=1; `grant_idx_o`=0.
- Round-robin: hold `req_i`=4'b1111 and have each owner drop its bit for one cycle after 3 granted cycles → grants go 0,1,2,3,0 with no idle cycle between them.
- Wrap and skip: `last_q`=2 with `req_i`=4'b0011 → grant requester 0, not 1.
- IDLE return: the sole owner (requester 1) drops its request with `req_i`=0 → `grant_o`=0 and `grant_valid_o`=0 the next cycle. A later request from requester 1 with 3 also requesting → requester 3 wins.
- Hold limit (macro defined, MAX_HOLD=4): requester 0 holds its request high and requester 2 requests → requester 0 is granted for exactly 4 cycles, then requester 2 is granted and `preempt_o`=1 for 1 cycle. Repeat with only requester 0 requesting → no preempt and the grant stays.
- Mid-grant reset: pulse `rst_n`=0 for 1 cycle while requester 2 owns the grant → `grant_o`=0 the next cycle, then requester 0 is granted first if it is requesting.
